alu_operand_sequencer: RTL and testbench

- Upstream stimulus stage for the 4-bit ALU top level: drives the registered operand inputs (a, b) and the opcode select (sel).
- Sweeps every opcode, with both operands covering every 4-bit value in signed ascending order (-8..7).
- Holds each vector for a programmable number of cycles so the ALU's registered 6-bit result can settle and be sampled.
- Exposes a vector-valid strobe and a vector index so a downstream checker can align results to stimulus.

---
 rtl/alu_operand_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: stimulus generator for the 4-bit ALU.
// It sweeps opcode (sel), then operand a, then operand b. Both operands run in
// signed ascending order -8..7. Each vector is held for HOLD_CYCLES clocks, and
// a vec_valid strobe and a vec_idx tag let a checker align results to stimulus.
// Optional feature: define SEQ_SEL_MASK_EN to add a sel_mask input. The mask is
// captured at start, and opcodes whose mask bit is 0 are skipped.
module alu_operand_sequencer #(
  parameter int HOLD_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
`ifdef SEQ_SEL_MASK_EN
  input  logic [15:0]        sel_mask,
`endif
  output logic signed [3:0]  a,
  output logic signed [3:0]  b,
  output logic [3:0]         sel,
  output logic               vec_valid,
  output logic [11:0]        vec_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic signed [3:0] a_n, b_n;
  logic [3:0]        sel_n;
  logic [11:0]       idx_n;
  logic              valid_n, busy_n, done_n;
  logic [15:0]       mask_q, mask_n;
  logic [15:0]       start_mask;
  logic [4:0]        first_sel;
  logic [4:0]        next_sel;

  // Signed ascending step. Two's complement wrap takes 7 to -8.
  function automatic logic signed [3:0] step_signed(input logic signed [3:0] v);
    return v + 4'sd1;
  endfunction

  // Lowest enabled opcode at or above 'from'. Bit 4 set means none is left.
  function automatic logic [4:0] first_enabled(input logic [15:0] m, input logic [4:0] from);
    logic [4:0] r;
    r = 5'd16;
    for (int i = 15; i >= 0; i--) begin
      if (m[i] && (5'(i) >= from)) r = 5'(i);
    end
    return r;
  endfunction

`ifdef SEQ_SEL_MASK_EN
  assign start_mask = sel_mask;
`else
  assign start_mask = 16'hFFFF;
`endif

  assign first_sel = first_enabled(start_mask, 5'd0);
  assign next_sel  = first_enabled(mask_q, {1'b0, sel} + 5'd1);

  // Next-state and next-output decode. Every register holds unless told otherwise.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = a;
    b_n     = b;
    sel_n   = sel;
    idx_n   = vec_idx;
    valid_n = 1'b0;
    busy_n  = busy;
    done_n  = done;
    mask_n  = mask_q;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          mask_n = start_mask;
          if (first_sel[4]) begin
            // Nothing to issue: finish immediately and leave the outputs untouched.
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = HOLD;
            sel_n   = first_sel[3:0];
            a_n     = 4'sh8;                      // -8, the first operand value
            b_n     = 4'sh8;
            idx_n   = {first_sel[3:0], 8'h00};
            valid_n = 1'b1;
            busy_n  = 1'b1;
            done_n  = 1'b0;
            cnt_n   = RELOAD;
          end
        end
      end
      HOLD: begin
        if (!pause) begin
          if (cnt != 8'd0) begin
            cnt_n = cnt - 8'd1;
          end else if (a == 4'sd7 && b == 4'sd7 && next_sel[4]) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            b_n = step_signed(b);
            if (b == 4'sd7) begin
              a_n = step_signed(a);
              if (a == 4'sd7) sel_n = next_sel[3:0];
            end
            idx_n   = {sel_n, $unsigned(a_n) ^ 4'h8, $unsigned(b_n) ^ 4'h8};
            valid_n = 1'b1;
            cnt_n   = RELOAD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers. Synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      a         <= 4'sd0;
      b         <= 4'sd0;
      sel       <= 4'd0;
      vec_idx   <= 12'd0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mask_q    <= 16'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      a         <= a_n;
      b         <= b_n;
      sel       <= sel_n;
      vec_idx   <= idx_n;
      vec_valid <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
      mask_q    <= mask_n;
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Testbench for alu_operand_sequencer. There are two instances: dut3 has a hold
// of 3 cycles and dut1 a hold of 1 cycle. A cycle-level reference model works on
// the vector ordinal, and the tests compare against it. The sel_mask tests are
// built only when SEQ_SEL_MASK_EN is defined.
module tb_alu_operand_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3, start3, pause3, rst1, start1, pause1;
  logic signed [3:0] a3, b3, a1, b1;
  logic [3:0] sel3, sel1;
  logic vv3, vv1, busy3, busy1, done3, done1;
  logic [11:0] idx3, idx1;
  logic [15:0] msk_now;
  logic [26:0] obs3, obs1;
  int errors = 0;
  int checks = 0;

`ifdef SEQ_SEL_MASK_EN
  logic [15:0] mask_in = 16'hFFFF;
  assign msk_now = mask_in;
`else
  assign msk_now = 16'hFFFF;
`endif

  alu_operand_sequencer #(.HOLD_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .start(start3), .pause(pause3),
`ifdef SEQ_SEL_MASK_EN
    .sel_mask(mask_in),
`endif
    .a(a3), .b(b3), .sel(sel3), .vec_valid(vv3), .vec_idx(idx3),
    .busy(busy3), .done(done3));

  alu_operand_sequencer #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .pause(pause1),
`ifdef SEQ_SEL_MASK_EN
    .sel_mask(mask_in),
`endif
    .a(a1), .b(b1), .sel(sel1), .vec_valid(vv1), .vec_idx(idx1),
    .busy(busy1), .done(done1));

  assign obs3 = {sel3, a3, b3, vv3, idx3, busy3, done3};
  assign obs1 = {sel1, a1, b1, vv1, idx1, busy1, done1};

  // Reference model. It tracks the vector ordinal, the remaining hold cycles and
  // the flags; the outputs are derived from the ordinal arithmetically.
  typedef struct {
    bit          started;
    bit          busy;
    bit          done;
    int          idx;
    int          left;
    bit          valid;
    logic [15:0] mask;
  } mdl_t;

  mdl_t m3 = '{default: 0};
  mdl_t m1 = '{default: 0};

  function automatic int lowest_en(logic [15:0] m, int from);
    for (int s = from; s < 16; s++) if (m[s]) return s;
    return -1;
  endfunction

  function automatic mdl_t step(mdl_t s, bit r, bit st, bit p, logic [15:0] msk, int h);
    mdl_t n;
    int f;
    n = s;
    n.valid = 1'b0;
    if (r) begin
      n.started = 0; n.busy = 0; n.done = 0; n.idx = 0; n.left = 0; n.mask = '0;
    end else if (!s.busy) begin
      if (st) begin
        n.mask = msk;
        f = lowest_en(msk, 0);
        if (f < 0) n.done = 1;
        else begin
          n.started = 1; n.busy = 1; n.done = 0; n.idx = f * 256; n.left = h - 1; n.valid = 1;
        end
      end
    end else if (!p) begin
      if (s.left > 0) n.left = s.left - 1;
      else begin
        if (s.idx % 256 != 255) f = s.idx + 1;
        else begin
          f = lowest_en(s.mask, s.idx / 256 + 1);
          if (f >= 0) f = f * 256;
        end
        if (f < 0) begin n.busy = 0; n.done = 1; end
        else begin n.idx = f; n.left = h - 1; n.valid = 1; end
      end
    end
    return n;
  endfunction

  function automatic logic [26:0] ex_word(mdl_t s);
    logic [3:0] es, ea, eb;
    if (s.started) begin
      es = 4'(s.idx / 256);
      ea = 4'((s.idx / 16) % 16) ^ 4'h8;
      eb = 4'(s.idx % 16) ^ 4'h8;
    end else begin
      es = 4'd0; ea = 4'd0; eb = 4'd0;
    end
    return {es, ea, eb, s.valid, 12'(s.idx), s.busy, s.done};
  endfunction

  // Advance the model on the same edge the DUTs sample their inputs.
  always @(posedge clk) begin
    m3 = step(m3, rst3, start3, pause3, msk_now, 3);
    m1 = step(m1, rst1, start1, pause1, msk_now, 1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst3 = 1; rst1 = 1; start3 = 0; start1 = 0; pause3 = 0; pause1 = 0;
    repeat (2) tick();
    checks++;
    if (obs3 !== 27'd0) begin errors++; $display("FAIL reset3 got=%h exp=%h", obs3, 27'd0); end
    checks++;
    if (obs1 !== 27'd0) begin errors++; $display("FAIL reset1 got=%h exp=%h", obs1, 27'd0); end
    rst3 = 0; rst1 = 0;
    repeat (3) tick();
    checks++;
    if (obs3 !== ex_word(m3)) begin errors++; $display("FAIL idle3 got=%h exp=%h", obs3, ex_word(m3)); end
    checks++;
    if (obs1 !== 27'd0) begin errors++; $display("FAIL idle1 got=%h exp=%h", obs1, 27'd0); end
  endtask

  task automatic test_basic_start();
    start3 = 1; pause3 = 1;    // pause has no effect outside HOLD
    tick();
    start3 = 0; pause3 = 0;
    checks++;
    if (obs3 !== {4'h0, 4'h8, 4'h8, 1'b1, 12'd0, 1'b1, 1'b0})
      begin errors++; $display("FAIL first_vec got=%h exp=%h", obs3, {4'h0, 4'h8, 4'h8, 1'b1, 12'd0, 1'b1, 1'b0}); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (vv3 !== 1'b0 || idx3 !== 12'd0) begin errors++; $display("FAIL hold0 vv=%b idx=%0d exp vv=0 idx=0", vv3, idx3); end
    end
    tick();
    checks++;
    if (obs3 !== {4'h0, 4'h8, 4'h9, 1'b1, 12'd1, 1'b1, 1'b0})
      begin errors++; $display("FAIL second_vec got=%h exp=%h", obs3, {4'h0, 4'h8, 4'h9, 1'b1, 12'd1, 1'b1, 1'b0}); end
  endtask

  task automatic test_wrap();
    int n = 0;
    int pulses = 0;
    while (!(idx3 == 12'd16 && vv3 === 1'b1) && n < 200) begin
      tick(); n++;
      if (vv3 === 1'b1) pulses++;
      checks++;
      if (obs3 !== ex_word(m3)) begin errors++; $display("FAIL wrap_cyc got=%h exp=%h", obs3, ex_word(m3)); end
    end
    checks++;
    if (obs3 !== {4'h0, 4'h9, 4'h8, 1'b1, 12'd16, 1'b1, 1'b0})
      begin errors++; $display("FAIL a_wrap got=%h exp=%h", obs3, {4'h0, 4'h9, 4'h8, 1'b1, 12'd16, 1'b1, 1'b0}); end
    checks++;
    if (pulses != 15) begin errors++; $display("FAIL pulse_count got=%0d exp=15", pulses); end
  endtask

  task automatic test_pause();
    int n = 0;
    int n20 = 0;
    while (!(idx3 == 12'd20 && vv3 === 1'b1) && n < 100) begin
      tick(); n++;
      checks++;
      if (obs3 !== ex_word(m3)) begin errors++; $display("FAIL pre_pause got=%h exp=%h", obs3, ex_word(m3)); end
    end
    n20 = 1;
    tick();
    if (idx3 == 12'd20) n20++;
    pause3 = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (idx3 == 12'd20) n20++;
      checks++;
      if (vv3 !== 1'b0 || obs3 !== ex_word(m3))
        begin errors++; $display("FAIL paused got=%h exp=%h", obs3, ex_word(m3)); end
    end
    pause3 = 0;
    n = 0;
    while (idx3 != 12'd21 && n < 20) begin
      tick(); n++;
      if (idx3 == 12'd20) n20++;
    end
    checks++;
    if (n20 != 8) begin errors++; $display("FAIL pause_len got=%0d exp=8", n20); end
    checks++;
    if (idx3 !== 12'd21 || vv3 !== 1'b1) begin errors++; $display("FAIL after_pause idx=%0d vv=%b exp idx=21 vv=1", idx3, vv3); end
  endtask

  task automatic test_sel_wrap();
    int n = 0;
    logic [11:0] prev = 12'd0;
    while (!(idx3 == 12'd256) && n < 1000) begin
      prev = idx3;
      tick(); n++;
      checks++;
      if (obs3 !== ex_word(m3)) begin errors++; $display("FAIL selwrap_cyc got=%h exp=%h", obs3, ex_word(m3)); end
    end
    checks++;
    if (obs3 !== {4'h1, 4'h8, 4'h8, 1'b1, 12'd256, 1'b1, 1'b0} || prev !== 12'd255)
      begin errors++; $display("FAIL sel_wrap got=%h prev=%0d exp=%h prev=255", obs3, prev, {4'h1, 4'h8, 4'h8, 1'b1, 12'd256, 1'b1, 1'b0}); end
  endtask

  task automatic test_random_busy();
    for (int i = 0; i < 1500; i++) begin
      pause3 = ($urandom_range(0, 3) == 0);
      start3 = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (obs3 !== ex_word(m3)) begin errors++; $display("FAIL random got=%h exp=%h", obs3, ex_word(m3)); end
    end
    pause3 = 0; start3 = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    rst3 = 1; tick(); rst3 = 0;
    start3 = 1; tick(); start3 = 0;
    while (idx3 != 12'd100 && n < 400) begin
      tick(); n++;
      checks++;
      if (obs3 !== ex_word(m3)) begin errors++; $display("FAIL to100 got=%h exp=%h", obs3, ex_word(m3)); end
    end
    rst3 = 1; tick(); rst3 = 0;
    checks++;
    if (obs3 !== 27'd0) begin errors++; $display("FAIL mid_reset got=%h exp=%h", obs3, 27'd0); end
    repeat (4) tick();
    checks++;
    if (obs3 !== 27'd0) begin errors++; $display("FAIL post_reset_idle got=%h exp=%h", obs3, 27'd0); end
  endtask

  task automatic test_completion();
    int pulses;
    start1 = 1; tick(); start1 = 0;
    pulses = (vv1 === 1'b1) ? 1 : 0;
    for (int obs = 2; obs <= 4097; obs++) begin
      tick();
      if (vv1 === 1'b1) pulses++;
      checks++;
      if (obs1 !== ex_word(m1)) begin errors++; $display("FAIL sweep1 obs=%0d got=%h exp=%h", obs, obs1, ex_word(m1)); end
      if (obs == 4096) begin
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL pre_done done=%b busy=%b exp 0 1", done1, busy1); end
      end
    end
    checks++;
    if (obs1 !== {4'hF, 4'h7, 4'h7, 1'b0, 12'd4095, 1'b0, 1'b1})
      begin errors++; $display("FAIL done_state got=%h exp=%h", obs1, {4'hF, 4'h7, 4'h7, 1'b0, 12'd4095, 1'b0, 1'b1}); end
    checks++;
    if (pulses != 4096) begin errors++; $display("FAIL total_pulses got=%0d exp=4096", pulses); end
    repeat (5) tick();
    checks++;
    if (obs1 !== {4'hF, 4'h7, 4'h7, 1'b0, 12'd4095, 1'b0, 1'b1})
      begin errors++; $display("FAIL done_hold got=%h exp=%h", obs1, {4'hF, 4'h7, 4'h7, 1'b0, 12'd4095, 1'b0, 1'b1}); end
    start1 = 1; tick(); start1 = 0;
    checks++;
    if (obs1 !== {4'h0, 4'h8, 4'h8, 1'b1, 12'd0, 1'b1, 1'b0})
      begin errors++; $display("FAIL restart got=%h exp=%h", obs1, {4'h0, 4'h8, 4'h8, 1'b1, 12'd0, 1'b1, 1'b0}); end
  endtask

`ifdef SEQ_SEL_MASK_EN
  task automatic test_mask();
    int n = 0;
    int pulses = 1;
    logic [11:0] prev = 12'd0;
    bit saw512 = 0;
    rst1 = 1; tick(); rst1 = 0;
    mask_in = 16'h0005;
    start1 = 1; tick(); start1 = 0;
    mask_in = 16'hFFFF;          // ignored until the next start
    checks++;
    if (obs1 !== {4'h0, 4'h8, 4'h8, 1'b1, 12'd0, 1'b1, 1'b0})
      begin errors++; $display("FAIL mask_first got=%h", obs1); end
    while (done1 !== 1'b1 && n < 700) begin
      prev = idx1;
      tick(); n++;
      if (vv1 === 1'b1) pulses++;
      if (vv1 === 1'b1 && idx1 == 12'd512) begin
        saw512 = 1;
        checks++;
        if (prev !== 12'd255 || sel1 !== 4'd2) begin errors++; $display("FAIL mask_jump prev=%0d sel=%0d exp 255 2", prev, sel1); end
      end
      checks++;
      if (obs1 !== ex_word(m1)) begin errors++; $display("FAIL mask_cyc got=%h exp=%h", obs1, ex_word(m1)); end
    end
    checks++;
    if (pulses != 512 || !saw512) begin errors++; $display("FAIL mask_pulses got=%0d seen512=%0d exp 512 1", pulses, saw512); end
    mask_in = 16'h0000;
    start1 = 1; tick(); start1 = 0;
    pulses = (vv1 === 1'b1) ? 1 : 0;
    checks++;
    if (obs1 !== {4'h2, 4'h7, 4'h7, 1'b0, 12'h2FF, 1'b0, 1'b1})
      begin errors++; $display("FAIL mask_zero got=%h exp=%h", obs1, {4'h2, 4'h7, 4'h7, 1'b0, 12'h2FF, 1'b0, 1'b1}); end
    for (int i = 0; i < 5; i++) begin tick(); if (vv1 === 1'b1) pulses++; end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL mask_zero_pulses got=%0d exp=0", pulses); end
    mask_in = 16'hFFFF;
  endtask
`endif

  initial begin
    rst3 = 1; rst1 = 1; start3 = 0; start1 = 0; pause3 = 0; pause1 = 0;
    @(negedge clk);
    test_reset();
    test_basic_start();
    test_wrap();
    test_pause();
    test_sel_wrap();
    test_random_busy();
    test_reset_mid();
    test_completion();
`ifdef SEQ_SEL_MASK_EN
    test_mask();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
